// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-unit result FIFOs feeding a round-robin arbiter
// and a registered broadcast. Unit order is 0=int, 1=mem, 2=mult, 3=div.
module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              int_sub_valid,
    input  logic [TAG_W-1:0]  int_sub_tag,
    input  logic [DATA_W-1:0] int_sub_data,
    input  logic              int_sub_branch,
    input  logic              int_sub_branch_taken,
    output logic              int_sub_rdy,
    input  logic              mem_sub_valid,
    input  logic [TAG_W-1:0]  mem_sub_tag,
    input  logic [DATA_W-1:0] mem_sub_data,
    output logic              mem_sub_rdy,
    input  logic              mult_sub_valid,
    input  logic [TAG_W-1:0]  mult_sub_tag,
    input  logic [DATA_W-1:0] mult_sub_data,
    output logic              mult_sub_rdy,
    input  logic              div_sub_valid,
    input  logic [TAG_W-1:0]  div_sub_tag,
    input  logic [DATA_W-1:0] div_sub_data,
    output logic              div_sub_rdy,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_branch_taken,
    output logic              o_busy
);

    localparam int NU    = 4;
    localparam int E_W   = 2 + TAG_W + DATA_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [NU-1:0]    in_valid;
    logic [NU-1:0]    push;
    logic [NU-1:0]    pop;
    logic [NU-1:0]    req;
    logic [NU-1:0]    rdy;
    logic [E_W-1:0]   in_entry [NU];
    logic [E_W-1:0]   store    [NU][DEPTH];
    logic [PTR_W-1:0] wr_ptr   [NU];
    logic [PTR_W-1:0] rd_ptr   [NU];
    logic [CNT_W-1:0] count    [NU];
    logic [1:0]       rr_ptr;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic             gnt_any;
    logic [E_W-1:0]   head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_valid = {div_sub_valid, mult_sub_valid, mem_sub_valid, int_sub_valid};

    // Taken is qualified by branch so the broadcast never shows taken without branch.
    always_comb begin
        in_entry[0] = {int_sub_branch, int_sub_branch & int_sub_branch_taken,
                       int_sub_tag, int_sub_data};
        in_entry[1] = {2'b00, mem_sub_tag, mem_sub_data};
        in_entry[2] = {2'b00, mult_sub_tag, mult_sub_data};
        in_entry[3] = {2'b00, div_sub_tag, div_sub_data};
    end

    always_comb begin
        req = '0;
        for (int u = 0; u < NU; u++) begin
            req[u] = (count[u] != '0);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        pop     = '0;
        for (int i = 0; i < NU; i++) begin
            cand = rr_ptr + 2'(i);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    // A full buffer whose head leaves this cycle can still take a new result.
    always_comb begin
        rdy  = '0;
        push = '0;
        for (int u = 0; u < NU; u++) begin
            rdy[u]  = (count[u] < FULL) | pop[u];
            push[u] = in_valid[u] & rdy[u];
        end
    end

    assign head = store[gnt_idx][rd_ptr[gnt_idx]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int u = 0; u < NU; u++) begin
                wr_ptr[u] <= '0;
                rd_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (push[u]) begin
                    wr_ptr[u] <= ptr_inc(wr_ptr[u]);
                end
                if (pop[u]) begin
                    rd_ptr[u] <= ptr_inc(rd_ptr[u]);
                end
                if (push[u] && !pop[u]) begin
                    count[u] <= count[u] + 1'b1;
                end else if (!push[u] && pop[u]) begin
                    count[u] <= count[u] - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the counters.
    always_ff @(posedge i_clk) begin
        for (int u = 0; u < NU; u++) begin
            if (push[u]) begin
                store[u][wr_ptr[u]] <= in_entry[u];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr           <= '0;
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end else if (gnt_any) begin
            rr_ptr    <= gnt_idx + 2'd1;
            cdb_valid <= 1'b1;
            {cdb_branch, cdb_branch_taken, cdb_tag, cdb_data} <= head;
        end else begin
            cdb_valid        <= 1'b0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end
    end

    assign int_sub_rdy  = rdy[0];
    assign mem_sub_rdy  = rdy[1];
    assign mult_sub_rdy = rdy[2];
    assign div_sub_rdy  = rdy[3];
    assign o_busy       = (|req) | cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed broadcast sequences for single,
// simultaneous, back-pressured, branch, full-buffer and mid-run reset scenarios.
module tb_cdb_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic        int_sub_valid;
    logic [5:0]  int_sub_tag;
    logic [31:0] int_sub_data;
    logic        int_sub_branch;
    logic        int_sub_branch_taken;
    logic        int_sub_rdy;
    logic        mem_sub_valid;
    logic [5:0]  mem_sub_tag;
    logic [31:0] mem_sub_data;
    logic        mem_sub_rdy;
    logic        mult_sub_valid;
    logic [5:0]  mult_sub_tag;
    logic [31:0] mult_sub_data;
    logic        mult_sub_rdy;
    logic        div_sub_valid;
    logic [5:0]  div_sub_tag;
    logic [31:0] div_sub_data;
    logic        div_sub_rdy;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_branch;
    logic        cdb_branch_taken;
    logic        o_busy;

    int n_vec;
    int n_err;

    cdb_arbiter #(.DEPTH(2), .TAG_W(6), .DATA_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .int_sub_valid(int_sub_valid), .int_sub_tag(int_sub_tag), .int_sub_data(int_sub_data),
        .int_sub_branch(int_sub_branch), .int_sub_branch_taken(int_sub_branch_taken),
        .int_sub_rdy(int_sub_rdy),
        .mem_sub_valid(mem_sub_valid), .mem_sub_tag(mem_sub_tag), .mem_sub_data(mem_sub_data),
        .mem_sub_rdy(mem_sub_rdy),
        .mult_sub_valid(mult_sub_valid), .mult_sub_tag(mult_sub_tag), .mult_sub_data(mult_sub_data),
        .mult_sub_rdy(mult_sub_rdy),
        .div_sub_valid(div_sub_valid), .div_sub_tag(div_sub_tag), .div_sub_data(div_sub_data),
        .div_sub_rdy(div_sub_rdy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
        .o_busy(o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr();
        int_sub_valid = 1'b0; int_sub_tag = '0; int_sub_data = '0;
        int_sub_branch = 1'b0; int_sub_branch_taken = 1'b0;
        mem_sub_valid = 1'b0; mem_sub_tag = '0; mem_sub_data = '0;
        mult_sub_valid = 1'b0; mult_sub_tag = '0; mult_sub_data = '0;
        div_sub_valid = 1'b0; div_sub_tag = '0; div_sub_data = '0;
    endtask

    // Data convention for most vectors: data = 0x1000_0000 + tag.
    task automatic set_unit(input int u, input logic v, input logic [5:0] tag);
        case (u)
            0: begin int_sub_valid = v; int_sub_tag = tag; int_sub_data = 32'h1000_0000 | 32'(tag); end
            1: begin mem_sub_valid = v; mem_sub_tag = tag; mem_sub_data = 32'h1000_0000 | 32'(tag); end
            2: begin mult_sub_valid = v; mult_sub_tag = tag; mult_sub_data = 32'h1000_0000 | 32'(tag); end
            default: begin div_sub_valid = v; div_sub_tag = tag; div_sub_data = 32'h1000_0000 | 32'(tag); end
        endcase
    endtask

    task automatic expect_cdb(input string name, input logic [5:0] tag);
        chk_bit({name, "_valid"}, cdb_valid, 1'b1);
        chk_word({name, "_tag"}, 32'(cdb_tag), 32'(tag));
        chk_word({name, "_data"}, cdb_data, 32'h1000_0000 | 32'(tag));
    endtask

    task automatic expect_idle(input string name);
        chk_bit({name, "_valid"}, cdb_valid, 1'b0);
        chk_bit({name, "_busy"}, o_busy, 1'b0);
    endtask

    task automatic do_reset();
        clr();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clr();
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        chk_bit("rst_valid", cdb_valid, 1'b0);
        chk_word("rst_tag", 32'(cdb_tag), 32'h0);
        chk_word("rst_data", cdb_data, 32'h0);
        chk_bit("rst_branch", cdb_branch, 1'b0);
        chk_bit("rst_taken", cdb_branch_taken, 1'b0);
        chk_bit("rst_busy", o_busy, 1'b0);
        chk_word("rst_rdy", {28'h0, div_sub_rdy, mult_sub_rdy, mem_sub_rdy, int_sub_rdy}, 32'hF);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Single int result: broadcast two edges after acceptance.
        int_sub_valid = 1'b1; int_sub_tag = 6'h05; int_sub_data = 32'h0000_00AA;
        tick();
        clr();
        chk_bit("t1_nobypass", cdb_valid, 1'b0);
        chk_bit("t1_busy_buf", o_busy, 1'b1);
        tick();
        chk_bit("t1_valid", cdb_valid, 1'b1);
        chk_word("t1_tag", 32'(cdb_tag), 32'h05);
        chk_word("t1_data", cdb_data, 32'hAA);
        chk_bit("t1_branch", cdb_branch, 1'b0);
        tick();
        expect_idle("t1_end");

        // All four units at once from pointer 0, then int/div to confirm pointer wrapped to 0.
        do_reset();
        set_unit(0, 1'b1, 6'd1); set_unit(1, 1'b1, 6'd2);
        set_unit(2, 1'b1, 6'd3); set_unit(3, 1'b1, 6'd4);
        tick();
        clr();
        chk_bit("t2_nobypass", cdb_valid, 1'b0);
        tick(); expect_cdb("t2_b1", 6'd1);
        tick(); expect_cdb("t2_b2", 6'd2);
        tick(); expect_cdb("t2_b3", 6'd3);
        tick(); expect_cdb("t2_b4", 6'd4);
        set_unit(3, 1'b1, 6'd9); set_unit(0, 1'b1, 6'd8);
        tick();
        clr();
        chk_bit("t2_gap", cdb_valid, 1'b0);
        tick(); expect_cdb("t2_p0_int", 6'd8);
        tick(); expect_cdb("t2_p0_div", 6'd9);
        tick(); expect_idle("t2_end");

        // Int back-pressure while mem/mult compete for the bus.
        do_reset();
        set_unit(0, 1'b1, 6'h11); set_unit(1, 1'b1, 6'h21); set_unit(2, 1'b1, 6'h31);
        tick();
        chk_bit("t3_nobypass", cdb_valid, 1'b0);
        set_unit(0, 1'b1, 6'h12); set_unit(1, 1'b0, 6'h00); set_unit(2, 1'b1, 6'h32);
        tick();
        expect_cdb("t3_b1", 6'h11);
        chk_bit("t3_int_rdy_a", int_sub_rdy, 1'b1);
        chk_bit("t3_mult_full", mult_sub_rdy, 1'b0);
        set_unit(0, 1'b1, 6'h13); set_unit(2, 1'b1, 6'h33);
        tick();
        expect_cdb("t3_b2", 6'h21);
        chk_bit("t3_int_full", int_sub_rdy, 1'b0);
        chk_bit("t3_mult_pop", mult_sub_rdy, 1'b1);
        set_unit(0, 1'b0, 6'h00);
        tick();
        expect_cdb("t3_b3", 6'h31);
        chk_bit("t3_int_pop", int_sub_rdy, 1'b1);
        clr();
        tick(); expect_cdb("t3_b4", 6'h12);
        tick(); expect_cdb("t3_b5", 6'h32);
        tick(); expect_cdb("t3_b6", 6'h13);
        tick(); expect_cdb("t3_b7", 6'h33);
        tick(); expect_idle("t3_end");

        // Branch resolutions.
        do_reset();
        set_unit(0, 1'b1, 6'h10); int_sub_branch = 1'b1; int_sub_branch_taken = 1'b1;
        tick();
        set_unit(0, 1'b1, 6'h11); int_sub_branch = 1'b1; int_sub_branch_taken = 1'b0;
        tick();
        clr();
        expect_cdb("t4_b1", 6'h10);
        chk_bit("t4_b1_br", cdb_branch, 1'b1);
        chk_bit("t4_b1_tk", cdb_branch_taken, 1'b1);
        tick();
        expect_cdb("t4_b2", 6'h11);
        chk_bit("t4_b2_br", cdb_branch, 1'b1);
        chk_bit("t4_b2_tk", cdb_branch_taken, 1'b0);
        tick();
        expect_idle("t4_idle");
        chk_bit("t4_idle_br", cdb_branch, 1'b0);
        chk_bit("t4_idle_tk", cdb_branch_taken, 1'b0);
        chk_word("t4_tag_hold", 32'(cdb_tag), 32'h11);

        // Full mult buffer granted while a new mult result arrives.
        do_reset();
        set_unit(0, 1'b1, 6'h11); set_unit(2, 1'b1, 6'h21);
        tick();
        set_unit(0, 1'b0, 6'h00); set_unit(2, 1'b1, 6'h22);
        chk_bit("t5_rdy0", mult_sub_rdy, 1'b1);
        tick();
        expect_cdb("t5_b1", 6'h11);
        chk_bit("t5_full_pop_rdy", mult_sub_rdy, 1'b1);
        set_unit(2, 1'b1, 6'h23);
        tick();
        expect_cdb("t5_b2", 6'h21);
        chk_bit("t5_rdy2", mult_sub_rdy, 1'b1);
        set_unit(2, 1'b1, 6'h24);
        tick();
        expect_cdb("t5_b3", 6'h22);
        set_unit(2, 1'b1, 6'h25);
        tick();
        expect_cdb("t5_b4", 6'h23);
        clr();
        tick(); expect_cdb("t5_b5", 6'h24);
        tick(); expect_cdb("t5_b6", 6'h25);
        tick(); expect_idle("t5_end");

        // Asynchronous reset with results buffered and a broadcast on the bus.
        do_reset();
        set_unit(0, 1'b1, 6'h31); set_unit(1, 1'b1, 6'h32); set_unit(2, 1'b1, 6'h33);
        tick();
        clr();
        tick();
        expect_cdb("t6_pre", 6'h31);
        #2 i_rst_n = 1'b0;
        #1;
        chk_bit("t6_valid", cdb_valid, 1'b0);
        chk_word("t6_tag", 32'(cdb_tag), 32'h0);
        chk_word("t6_data", cdb_data, 32'h0);
        chk_bit("t6_busy", o_busy, 1'b0);
        chk_bit("t6_int_rdy", int_sub_rdy, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick(); expect_idle("t6_post1");
        tick(); expect_idle("t6_post2");
        set_unit(2, 1'b1, 6'h34);
        tick();
        clr();
        tick(); expect_cdb("t6_fresh", 6'h34);
        tick(); expect_idle("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Producer end of the common data bus (CDB): collects completed results from the integer, load/store, multiply and divide execution units.
- Buffers each unit's results in a small per-unit queue.
- Picks one result per cycle by round-robin and drives the registered CDB broadcast. The dispatch stage, register status table, tag FIFO and reservation stations consume that broadcast.

Parameters:
- DEPTH, 2, entries per per-unit result buffer (power of two, ≥1).
- TAG_W, 6, tag width (64-entry tag space).
- DATA_W, 32, result data width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- int_sub_valid  in  1  integer unit result valid.
- int_sub_tag  in  TAG_W  integer result tag.
- int_sub_data  in  DATA_W  integer result data.
- int_sub_branch  in  1  result belongs to a branch instruction.
- int_sub_branch_taken  in  1  branch resolved taken (meaningful only with int_sub_branch).
- int_sub_rdy  out  1  integer buffer can accept.
- mem_sub_valid / mem_sub_tag / mem_sub_data  in  1/TAG_W/DATA_W  load/store result.
- mem_sub_rdy  out  1
- mult_sub_valid / mult_sub_tag / mult_sub_data  in  1/TAG_W/DATA_W  multiply result.
- mult_sub_rdy  out  1
- div_sub_valid / div_sub_tag / div_sub_data  in  1/TAG_W/DATA_W  divide result.
- div_sub_rdy  out  1
- cdb_valid  out  1  broadcast valid, one-cycle pulse per result.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast data.
- cdb_branch  out  1  broadcast is a branch resolution.
- cdb_branch_taken  out  1  branch taken; only ever 1 when cdb_branch=1.
- o_busy  out  1  any buffer non-empty or cdb_valid=1.

Behaviour:
- Unit indices: 0=int, 1=mem, 2=mult, 3=div.
- Reset, asynchronous on i_rst_n low:
  - all buffers empty.
  - cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken all 0.
  - RR pointer = 0.
  - all *_sub_rdy = 1.
  - o_busy = 0.
- Reset mid-operation discards all buffered and in-flight results; no partial broadcast after release.
- Per-unit buffer:
  - circular FIFO, DEPTH entries.
  - int entries store {branch, branch_taken, tag, data}; other units store {tag, data} with branch bits forced 0.
  - Push when sub_valid & sub_rdy at the rising edge.
  - sub_valid while sub_rdy=0 is ignored; the unit must hold the result.
- Ready rule:
  - sub_rdy = (count < DEPTH) | pop_this_cycle.
  - A full buffer whose head is granted this cycle accepts a new push in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Arbitration (combinational on buffer heads, each cycle):
  - Requesters are the non-empty buffers.
  - Search starts at the RR pointer p, ascending modulo 4; the first requester wins.
  - On a grant to g: pop buffer g, and p <= (g+1) mod 4.
  - With no requesters, p holds.
- CDB output register:
  - On grant: loaded with the winner's head; cdb_valid <= 1.
  - Otherwise cdb_valid <= 0. cdb_tag/cdb_data hold their last value; cdb_branch and cdb_branch_taken are cleared to 0.
  - At most one broadcast per cycle; every accepted result is broadcast exactly once.
- Latency:
  - Result accepted at edge k is buffered.
  - If it wins arbitration in the cycle after edge k, cdb_valid is high in the cycle after edge k+1.
  - Minimum latency: 2 edges from acceptance to broadcast visible.
- No bypass: a new submission cannot be broadcast in its own acceptance cycle.
- Fairness: with all four buffers continuously non-empty, each unit gets exactly 1 grant per 4 cycles; worst-case wait for a head = 3 cycles.
- Order: results from the same unit are broadcast in acceptance order; no ordering guarantee across units.
- Tags are passed through unchecked; the arbiter does not detect duplicate tags.

Test Plan:
1. Reset, then int_sub_valid=1 with tag=0x05, data=0x0000_00AA for 1 cycle → cdb_valid is a 1-cycle pulse 2 edges later with tag 0x05, data 0xAA, cdb_branch=0; o_busy returns to 0 on the following cycle.
2. All four units submit in the same cycle with tags 1 (int), 2 (mem), 3 (mult), 4 (div), p=0 → CDB broadcasts tags 1, 2, 3, 4 on consecutive cycles; p ends at 0.
3. Int submits 3 back-to-back results while never granted (DEPTH=2, mult saturating) → int_sub_rdy drops after 2 accepts; all 3 eventually broadcast in order, no loss or duplication.
4. Int submits branch with branch=1, taken=1, tag 0x10; then branch=1, taken=0, tag 0x11 → cdb_branch=1 on both broadcasts; cdb_branch_taken=1 then 0; cdb_branch=0 on idle cycles.
5. Full mult buffer granted while mult_sub_valid=1 → mult_sub_rdy=1 that cycle; count stays 2; 5 results total delivered in FIFO order.
6. Assert i_rst_n=0 asynchronously with 2 results buffered and cdb_valid=1 → all outputs 0 immediately; no stale broadcast after reset release.
